// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded instruction, operand sources and hazard inputs from ID,
// registered EX-side outputs and the combinational IF/ID stall back to the front end.
interface id_ex_stage_if #(
  parameter int unsigned CNT_W = 32
);
  logic             id_valid;
  logic [5:0]       id_opcode;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_dest;
  logic [31:0]      id_imm;
  logic [31:0]      id_pc;
  logic [31:0]      rf_rs_val;
  logic [31:0]      rf_rt_val;
  logic [31:0]      fwd_rs_data;
  logic [31:0]      fwd_rt_data;
  logic             fwd_rs_depends;
  logic             fwd_rt_depends;
  logic             fwd_rs_stall;
  logic             fwd_rt_stall;
  logic             ex_hold;
  logic             flush;
  logic             perf_clr;
  logic             id_stall;
  logic             ex_valid;
  logic [5:0]       ex_opcode;
  logic [4:0]       ex_dest;
  logic [31:0]      ex_a;
  logic [31:0]      ex_b;
  logic [31:0]      ex_imm;
  logic [31:0]      ex_pc;
  logic [1:0]       stage_state;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_dest, id_imm, id_pc,
           rf_rs_val, rf_rt_val, fwd_rs_data, fwd_rt_data,
           fwd_rs_depends, fwd_rt_depends, fwd_rs_stall, fwd_rt_stall,
           ex_hold, flush, perf_clr,
    input  id_stall, ex_valid, ex_opcode, ex_dest, ex_a, ex_b, ex_imm, ex_pc,
           stage_state, stall_cycles
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_dest, id_imm, id_pc,
           rf_rs_val, rf_rt_val, fwd_rs_data, fwd_rt_data,
           fwd_rs_depends, fwd_rt_depends, fwd_rs_stall, fwd_rt_stall,
           ex_hold, flush, perf_clr,
    output id_stall, ex_valid, ex_opcode, ex_dest, ex_a, ex_b, ex_imm, ex_pc,
           stage_state, stall_cycles
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding select, load-use bubble insertion,
// EX hold and branch flush. Define STALL_COUNTER_EN to build the load-use stall counter.
module id_ex_stage #(
  parameter logic [5:0]  NOP_OPCODE = 6'd0,
  parameter int unsigned CNT_W      = 32
) (
  input logic           clk,
  input logic           rst_n,
  id_ex_stage_if.slave  bus
);
   typedef enum logic [1:0] {RUN = 2'd0, BUBBLE = 2'd1, HOLD = 2'd2} stage_t;

   stage_t      state_q, state_d;
   logic        valid_q, valid_d;
   logic [5:0]  op_q, op_d;
   logic [4:0]  dest_q, dest_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] imm_q, imm_d;
   logic [31:0] pc_q, pc_d;
   logic        hazard;
   logic        id_stall_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         valid_q <= 1'b0;
         op_q    <= NOP_OPCODE;
         dest_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         op_q    <= op_d;
         dest_q  <= dest_d;
         a_q     <= a_d;
         b_q     <= b_d;
         imm_q   <= imm_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      hazard     = bus.id_valid & (bus.fwd_rs_stall | bus.fwd_rt_stall);
      state_d    = RUN;
      id_stall_c = 1'b0;
      valid_d    = valid_q;
      op_d       = op_q;
      dest_d     = dest_q;
      a_d        = a_q;
      b_d        = b_q;
      imm_d      = imm_q;
      pc_d       = pc_q;
      if (bus.ex_hold) begin
         state_d    = HOLD;
         id_stall_c = ~bus.flush;
      end else if (bus.flush | hazard) begin
         // Flush and load-use share the bubble load; only a genuine hazard stalls IF/ID.
         valid_d = 1'b0;
         op_d    = NOP_OPCODE;
         dest_d  = '0;
         a_d     = '0;
         b_d     = '0;
         imm_d   = '0;
         pc_d    = bus.id_pc;
         if (!bus.flush) begin
            state_d    = BUBBLE;
            id_stall_c = 1'b1;
         end
      end else begin
         valid_d = bus.id_valid;
         op_d    = bus.id_opcode;
         dest_d  = bus.id_valid ? bus.id_dest : '0;
         a_d     = bus.fwd_rs_depends ? bus.fwd_rs_data : bus.rf_rs_val;
         b_d     = bus.fwd_rt_depends ? bus.fwd_rt_data : bus.rf_rt_val;
         imm_d   = bus.id_imm;
         pc_d    = bus.id_pc;
      end
   end

   assign bus.id_stall    = id_stall_c;
   assign bus.ex_valid    = valid_q;
   assign bus.ex_opcode   = op_q;
   assign bus.ex_dest     = dest_q;
   assign bus.ex_a        = a_q;
   assign bus.ex_b        = b_q;
   assign bus.ex_imm      = imm_q;
   assign bus.ex_pc       = pc_q;
   assign bus.stage_state = state_q;

`ifdef STALL_COUNTER_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic             stall_inc;

   assign stall_inc = ~bus.ex_hold & ~bus.flush & hazard;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt_q <= '0;
      else if (bus.perf_clr)
         stall_cnt_q <= '0;
      else if (stall_inc && (stall_cnt_q != '1))
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
   end

   assign bus.stall_cycles = stall_cnt_q;
`else
   assign bus.stall_cycles = '0;
`endif
endmodule
